// File: rtl/sm4_masked_sbox_layer.sv
// Masked SM4 non-linear layer (tau): LANES masked bytes pushed through CORES
// time-multiplexed S-box cores, with valid/ready handshakes, flush and drain.

module sm4_sbox #(
  parameter int unsigned SBOX_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [7:0] m,
  output logic       finish,
  output logic [7:0] x_out,
  output logic [7:0] m_out
);
  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  logic [SBOX_LAT-1:0] pipe;

  assign finish = pipe[SBOX_LAT-1];

  // Output mask reuses the input mask; result is re-masked with it at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe  <= '0;
      x_out <= '0;
      m_out <= '0;
    end else begin
      pipe <= (pipe << 1) | SBOX_LAT'(start);
      if (start) begin
        x_out <= SBOX[x ^ m] ^ m;
        m_out <= m;
      end
    end
  end
endmodule

module sm4_masked_sbox_layer #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned CORES    = 2,
  parameter int unsigned SBOX_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] x,
  input  logic [8*LANES-1:0] m,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] x_out,
  output logic [8*LANES-1:0] m_out,
  output logic               busy
);
  localparam int unsigned W  = 8 * LANES;
  localparam int unsigned P  = LANES / CORES;
  localparam int unsigned GW = (P > 1) ? $clog2(P) : 1;

  if (LANES % CORES != 0) begin : g_bad_cores
    $error("CORES must divide LANES");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  state_t            state, state_nx;
  logic [GW-1:0]     g;
  logic [W-1:0]      x_q, m_q, res_x, res_m, res_x_nx, res_m_nx;
  logic [CORES-1:0]  fin, done_q;
  logic [7:0]        cin_x [CORES];
  logic [7:0]        cin_m [CORES];
  logic [7:0]        cout_x [CORES];
  logic [7:0]        cout_m [CORES];
  logic              rst_n, all_done, last, accept, start, capture;

  assign rst_n    = ~rst;
  assign all_done = &(done_q | fin);
  assign last     = (g == GW'(P - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid && !flush) state_nx = ISSUE;
      ISSUE: state_nx = flush ? IDLE : WAIT;
      WAIT: begin
        // A finish arriving together with flush leaves nothing to drain.
        if (flush)         state_nx = all_done ? IDLE : DRAIN;
        else if (all_done) state_nx = last ? DONE : ISSUE;
      end
      DONE:  if (flush || out_ready) state_nx = IDLE;
      DRAIN: if (all_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    start   = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE:    accept  = in_valid && !flush;
      ISSUE:   start   = !flush;
      WAIT:    capture = all_done && !flush;
      default: ;
    endcase
  end

  // Lane routing for the current pass g: core c handles lane g*CORES+c.
  always_comb begin
    res_x_nx = res_x;
    res_m_nx = res_m;
    for (int unsigned c = 0; c < CORES; c++) begin
      cin_x[c] = x_q[(32'(g) * CORES + c) * 8 +: 8];
      cin_m[c] = m_q[(32'(g) * CORES + c) * 8 +: 8];
      res_x_nx[(32'(g) * CORES + c) * 8 +: 8] = cout_x[c];
      res_m_nx[(32'(g) * CORES + c) * 8 +: 8] = cout_m[c];
    end
  end

  for (genvar c = 0; c < int'(CORES); c++) begin : g_core
    sm4_sbox #(.SBOX_LAT(SBOX_LAT)) u_sbox (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .x      (cin_x[c]),
      .m      (cin_m[c]),
      .finish (fin[c]),
      .x_out  (cout_x[c]),
      .m_out  (cout_m[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g      <= '0;
      x_q    <= '0;
      m_q    <= '0;
      res_x  <= '0;
      res_m  <= '0;
      x_out  <= '0;
      m_out  <= '0;
      done_q <= '0;
    end else begin
      done_q <= start ? '0 : (done_q | fin);
      if (accept) begin
        x_q <= x;
        m_q <= m;
        g   <= '0;
      end
      if (capture) begin
        res_x <= res_x_nx;
        res_m <= res_m_nx;
        if (last) begin
          x_out <= res_x_nx;
          m_out <= res_m_nx;
        end else begin
          g <= g + GW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      busy      <= (state_nx != IDLE);
      out_valid <= (state_nx == DONE);
    end
  end
endmodule
